// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router output-side blocks: flit geometry
// (virtual-channel bit, hop-count field) and the output arbiter state encoding.
package router_pkg;

    localparam int FLIT_W  = 64;
    localparam int VC_BIT  = 63;  // 0 = even VC, 1 = odd VC
    localparam int HOP_MSB = 55;  // hop count field, carried through untouched
    localparam int HOP_LSB = 48;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/router_output_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches mask starting at index ptr and
// wrapping upward, returning the first set position as a one-hot grant and as
// a binary index. grant is all-zero when mask is empty (idx is then 0).
// Ports:
//   mask  in  N   candidate vector
//   ptr   in  IW  index with highest priority this cycle (must be < N)
//   grant out N   one-hot winner
//   idx   out IW  binary index of the winner
module rr_pick #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int j;

    // Walk offsets from farthest to nearest so the last hit written is the
    // one closest to ptr, i.e. the highest-priority eligible requester.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (mask[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// router_output_arbiter
// Shares one output-controller input among NUM_REQ local requesters. A
// separate round-robin pointer is kept per virtual channel; only flits whose
// VC bit matches the current link polarity may win. The winner's flit is
// registered and offered over a single req/ack handshake. An offer that sees
// no out_ack for WAIT_LIMIT cycles is withdrawn (stall pulse) and the pointer
// of that VC moves past the stalled requester.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous reset, active-high
//   polarity  in   link polarity (VC currently served)
//   req       in   NUM_REQ per-requester packet valid
//   di        in   NUM_REQ*DATA_W flits, requester i at [i*DATA_W +: DATA_W]
//   ack       out  NUM_REQ one-cycle accept pulse back to the requester
//   out_req   out  offer valid toward the output controller
//   out_ack   in   output controller accepted the offered flit
//   dout      out  DATA_W registered offered flit
//   gnt_id    out  index of the current grantee
//   stall     out  one-cycle pulse when an offer times out
module router_output_arbiter
    import router_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = FLIT_W,
    parameter int WAIT_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        polarity,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   di,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        out_req,
    input  logic                        out_ack,
    output logic [DATA_W-1:0]           dout,
    output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
    output logic                        stall
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t          state_reg, state_next;
    logic [DATA_W-1:0]   dout_reg, dout_next;
    logic [IW-1:0]       gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic                stall_reg, stall_next;
    logic [IW-1:0]       ptr_even_reg, ptr_even_next;
    logic [IW-1:0]       ptr_odd_reg, ptr_odd_next;
    logic [3:0]          wait_cnt_reg, wait_cnt_next;

    logic [DATA_W-1:0]   flit [NUM_REQ];
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       ptr_vc;
    logic [IW-1:0]       gnt_inc;

    // A requester that was just acked still shows its old req for one cycle;
    // masking it with ack_reg prevents granting the same flit twice.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign flit[gi] = di[gi*DATA_W +: DATA_W];
            assign elig[gi] = req[gi] && (flit[gi][VC_BIT] == polarity) && !ack_reg[gi];
        end
    endgenerate

    assign ptr_vc  = polarity ? ptr_odd_reg : ptr_even_reg;
    assign gnt_inc = (gnt_reg == IW'(NUM_REQ - 1)) ? '0 : gnt_reg + 1'b1;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .mask  (elig),
        .ptr   (ptr_vc),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        state_next    = state_reg;
        dout_next     = dout_reg;
        gnt_next      = gnt_reg;
        ack_next      = '0;
        stall_next    = 1'b0;
        ptr_even_next = ptr_even_reg;
        ptr_odd_next  = ptr_odd_reg;
        wait_cnt_next = wait_cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (|pick_grant) begin
                    dout_next     = flit[pick_idx];
                    gnt_next      = pick_idx;
                    wait_cnt_next = '0;
                    state_next    = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Pointer updates follow the VC of the offered flit, not the
                // current polarity, which may have toggled since the grant.
                if (out_ack) begin
                    ack_next   = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_reg;
                    state_next = ST_IDLE;
                    if (dout_reg[VC_BIT]) ptr_odd_next  = gnt_inc;
                    else                  ptr_even_next = gnt_inc;
                end else if (!req[gnt_reg]) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg == 4'(WAIT_LIMIT - 1)) begin
                    stall_next = 1'b1;
                    state_next = ST_IDLE;
                    if (dout_reg[VC_BIT]) ptr_odd_next  = gnt_inc;
                    else                  ptr_even_next = gnt_inc;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            dout_reg     <= '0;
            gnt_reg      <= '0;
            ack_reg      <= '0;
            stall_reg    <= 1'b0;
            ptr_even_reg <= '0;
            ptr_odd_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            dout_reg     <= dout_next;
            gnt_reg      <= gnt_next;
            ack_reg      <= ack_next;
            stall_reg    <= stall_next;
            ptr_even_reg <= ptr_even_next;
            ptr_odd_reg  <= ptr_odd_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign out_req = (state_reg == ST_OFFER);
    assign dout    = dout_reg;
    assign gnt_id  = gnt_reg;
    assign ack     = ack_reg;
    assign stall   = stall_reg;

endmodule

// File: tb/tb_router_output_arbiter.sv
module tb_router_output_arbiter;
    import router_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      polarity;
    logic [NUM_REQ-1:0]        req;
    logic [DATA_W-1:0]         di0, di1;
    logic [NUM_REQ*DATA_W-1:0] di;
    logic [NUM_REQ-1:0]        ack;
    logic                      out_req;
    logic                      out_ack;
    logic [DATA_W-1:0]         dout;
    logic [0:0]                gnt_id;
    logic                      stall;

    int n_checks = 0;
    int n_fail   = 0;

    assign di = {di1, di0};

    always #5 clk = ~clk;

    router_output_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WAIT_LIMIT(4)) dut (
        .clk      (clk),
        .reset    (rst),
        .polarity (polarity),
        .req      (req),
        .di       (di),
        .ack      (ack),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .dout     (dout),
        .gnt_id   (gnt_id),
        .stall    (stall)
    );

    // Advance one clock; outputs are then stable and new inputs take effect next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; polarity = 1'b0; req = '0; out_ack = 1'b0; di0 = '0; di1 = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; polarity = 1'b0; req = '0; out_ack = 1'b1; di0 = '0; di1 = '0;
        step();
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req: got %b expected 0", out_req); end
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", ack); end
        n_checks++; if (dout !== 64'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
        n_checks++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst = 1'b0;
        // out_ack while idle must not produce an ack
        step();
        n_checks++; if (ack !== 2'b00 || out_req !== 1'b0) begin n_fail++; $display("FAIL idle_out_ack: got ack=%b out_req=%b expected 00/0", ack, out_req); end
        out_ack = 1'b0;
        $display("reset: outputs cleared, idle out_ack ignored");
    endtask

    task automatic test_basic_grant();
        do_reset();
        di0 = 64'h0000_1111_2222_3333;
        di1 = 64'h0012_0000_0000_BEEF;
        req = 2'b11;
        step();
        n_checks++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL basic_out_req: got %b expected 1", out_req); end
        n_checks++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL basic_gnt_id: got %0d expected 0", gnt_id); end
        n_checks++; if (dout !== 64'h0000_1111_2222_3333) begin n_fail++; $display("FAIL basic_dout: got %h expected 0000111122223333", dout); end
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL basic_no_early_ack: got %b expected 00", ack); end
        $display("basic: granted requester %0d dout=%h", gnt_id, dout);
        out_ack = 1'b1;
        step();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL basic_ack: got %b expected 01", ack); end
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL basic_out_req_drop: got %b expected 0", out_req); end
        out_ack = 1'b0; req = 2'b00;
        step();
        n_checks++; if (ack !== 2'b00 || out_req !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse: got ack=%b out_req=%b expected 00/0", ack, out_req); end
        req = 2'b11;
        step();
        // ptr_even moved to 1 after accepting requester 0
        n_checks++; if (gnt_id !== 1'b1 || out_req !== 1'b1) begin n_fail++; $display("FAIL basic_rr_next: got gnt_id=%0d out_req=%b expected 1/1", gnt_id, out_req); end
        n_checks++; if (dout[HOP_MSB:HOP_LSB] !== 8'h12 || dout !== 64'h0012_0000_0000_BEEF) begin n_fail++; $display("FAIL basic_hop_passthru: got %h expected 001200000000beef", dout); end
        $display("basic: round-robin granted requester %0d dout=%h", gnt_id, dout);
        req = 2'b00;
        step();
    endtask

    task automatic test_polarity();
        do_reset();
        polarity = 1'b1; req = 2'b01; di0 = 64'h0000_0000_0000_0042;
        step();
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL pol_mismatch_1: got out_req=%b expected 0", out_req); end
        step();
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL pol_mismatch_2: got out_req=%b expected 0", out_req); end
        polarity = 1'b0;
        step();
        n_checks++; if (out_req !== 1'b1 || gnt_id !== 1'b0) begin n_fail++; $display("FAIL pol_match: got out_req=%b gnt_id=%0d expected 1/0", out_req, gnt_id); end
        $display("polarity: even flit offered once polarity=0");
        req = 2'b00;
        step();
    endtask

    task automatic test_vc_pointers();
        do_reset();
        polarity = 1'b1; req = 2'b11;
        di0 = 64'h8000_0000_0000_0A0A; di1 = 64'h8000_0000_0000_0B0B;
        step();
        n_checks++; if (gnt_id !== 1'b0 || dout !== 64'h8000_0000_0000_0A0A) begin n_fail++; $display("FAIL vc_odd_grant: got gnt_id=%0d dout=%h expected 0/80000000_00000a0a", gnt_id, dout); end
        out_ack = 1'b1;
        step();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL vc_odd_ack: got %b expected 01", ack); end
        out_ack = 1'b0; req = 2'b00;
        step();
        // ptr_odd=1 now, ptr_even must still be 0
        polarity = 1'b0; req = 2'b11;
        di0 = 64'h0000_0000_0000_0C0C; di1 = 64'h0000_0000_0000_0D0D;
        step();
        n_checks++; if (gnt_id !== 1'b0 || out_req !== 1'b1) begin n_fail++; $display("FAIL vc_even_independent: got gnt_id=%0d out_req=%b expected 0/1", gnt_id, out_req); end
        $display("vc: odd accept left even pointer at requester %0d", gnt_id);
        req = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 2'b11;
        di0 = 64'h0000_0000_0000_1000; di1 = 64'h0000_0000_0000_2001;
        step();
        n_checks++; if (gnt_id !== 1'b0 || out_req !== 1'b1) begin n_fail++; $display("FAIL to0_grant: got gnt_id=%0d out_req=%b expected 0/1", gnt_id, out_req); end
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++; if (out_req !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL to0_hold_%0d: got out_req=%b stall=%b expected 1/0", c, out_req, stall); end
        end
        step();
        n_checks++; if (out_req !== 1'b0 || stall !== 1'b1 || ack !== 2'b00) begin n_fail++; $display("FAIL to0_stall: got out_req=%b stall=%b ack=%b expected 0/1/00", out_req, stall, ack); end
        $display("timeout: requester 0 offer withdrawn with stall");
        step();
        n_checks++; if (gnt_id !== 1'b1 || out_req !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL to1_grant: got gnt_id=%0d out_req=%b stall=%b expected 1/1/0", gnt_id, out_req, stall); end
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++; if (out_req !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL to1_hold_%0d: got out_req=%b stall=%b expected 1/0", c, out_req, stall); end
        end
        step();
        n_checks++; if (out_req !== 1'b0 || stall !== 1'b1 || ack !== 2'b00) begin n_fail++; $display("FAIL to1_stall: got out_req=%b stall=%b ack=%b expected 0/1/00", out_req, stall, ack); end
        $display("timeout: requester 1 offer withdrawn with stall");
        step();
        n_checks++; if (gnt_id !== 1'b0 || out_req !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL to_ptr_wrap: got gnt_id=%0d out_req=%b stall=%b expected 0/1/0", gnt_id, out_req, stall); end
        req = 2'b00;
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 2'b11;
        di0 = 64'h0000_0000_0000_3000; di1 = 64'h0000_0000_0000_3001;
        step();
        n_checks++; if (gnt_id !== 1'b0 || out_req !== 1'b1) begin n_fail++; $display("FAIL wd_grant: got gnt_id=%0d out_req=%b expected 0/1", gnt_id, out_req); end
        req = 2'b10;
        step();
        n_checks++; if (out_req !== 1'b0 || ack !== 2'b00 || stall !== 1'b0) begin n_fail++; $display("FAIL wd_drop: got out_req=%b ack=%b stall=%b expected 0/00/0", out_req, ack, stall); end
        req = 2'b11;
        step();
        n_checks++; if (gnt_id !== 1'b0 || out_req !== 1'b1) begin n_fail++; $display("FAIL wd_ptr_kept: got gnt_id=%0d out_req=%b expected 0/1", gnt_id, out_req); end
        $display("withdraw: offer dropped, pointer unchanged");
        req = 2'b00;
        step();
    endtask

    task automatic test_ack_and_withdraw();
        do_reset();
        req = 2'b10; di1 = 64'h0000_0000_0000_4001;
        step();
        n_checks++; if (gnt_id !== 1'b1 || out_req !== 1'b1) begin n_fail++; $display("FAIL aw_grant: got gnt_id=%0d out_req=%b expected 1/1", gnt_id, out_req); end
        req = 2'b00; out_ack = 1'b1;
        step();
        n_checks++; if (ack !== 2'b10 || out_req !== 1'b0) begin n_fail++; $display("FAIL aw_ack_wins: got ack=%b out_req=%b expected 10/0", ack, out_req); end
        out_ack = 1'b0;
        step();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL aw_ack_one_cycle: got %b expected 00", ack); end
        $display("ack+withdraw: ack issued to requester 1");
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 2'b01; di0 = 64'h0000_0000_0000_5000;
        step();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0; req = 2'b10; di1 = 64'h0000_0000_0000_00A5;
        step();
        n_checks++; if (gnt_id !== 1'b1 || dout !== 64'hA5 || out_req !== 1'b1) begin n_fail++; $display("FAIL ar_pre_grant: got gnt_id=%0d dout=%h out_req=%b expected 1/a5/1", gnt_id, dout, out_req); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (out_req !== 1'b0 || ack !== 2'b00 || dout !== 64'h0 || gnt_id !== 1'b0) begin n_fail++; $display("FAIL ar_immediate_clear: got out_req=%b ack=%b dout=%h gnt_id=%0d expected all 0", out_req, ack, dout, gnt_id); end
        step();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL ar_no_ack: got %b expected 00", ack); end
        rst = 1'b0; req = 2'b11; di0 = 64'h0000_0000_0000_6000;
        step();
        n_checks++; if (gnt_id !== 1'b0 || out_req !== 1'b1) begin n_fail++; $display("FAIL ar_ptr_restart: got gnt_id=%0d out_req=%b expected 0/1", gnt_id, out_req); end
        $display("async reset: mid-offer clear, restart at requester %0d", gnt_id);
        req = 2'b00;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_grant();
        test_polarity();
        test_vc_pointers();
        test_timeout();
        test_withdraw();
        test_ack_and_withdraw();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
